adc_reset_sequencer: RTL and testbench
======================================

ADC_RESET_SEQUENCER -- requirements
Module: adc_reset_sequencer

Interface
REQ-001 SHALL have parameter reset_time_delay, default 32'h3: power-up cycles before the first automatic reset request.
REQ-002 SHALL have parameter ack_timeout, default 16'd1024: cycles allowed in each wait state.
REQ-003 SHALL have parameter settle_cycles, default 16'd16: post-release settle time.
REQ-004 SHALL have parameter max_retries, default 4'd3: retry limit, used only with ADC_RESET_RETRY_EN.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 base_clk  input  1  sole clock.
REQ-007 system_reset  input  1  synchronous, active-high reset.
REQ-008 sw_reset_req  input  1  single-cycle software request for an ADC reset.
REQ-009 adc_reset_active  input  1  reset line fed back from the ADC reset generator; treated as asynchronous.
REQ-010 reset_start  output  1  single-cycle pulse that initiates the reset generator.
REQ-011 reset_busy  output  1  high whenever the state is not IDLE.
REQ-012 reset_done  output  1  level; last sequence completed successfully.
REQ-013 reset_error  output  1  sticky; last sequence failed.
REQ-014 retry_count  output  4  retries consumed in the current sequence.
REQ-015 state  output  3  current FSM state encoding, for debug.

Function
REQ-016 States SHALL be POWERUP, IDLE, ASSERT, WAIT_ACK, WAIT_REL, SETTLE, FAIL.
REQ-017 adc_reset_active SHALL pass through a 2-flop synchronizer; "act_s" below denotes the synchronized value, delayed 2 cycles.
REQ-018 POWERUP: a 32-bit counter increments from 0; on reaching reset_time_delay, go to ASSERT.
REQ-019 IDLE: when sw_reset_req=1, go to ASSERT and clear reset_done, reset_error and retry_count in that same cycle.
REQ-020 ASSERT: reset_start=1 for exactly this one cycle; go to WAIT_ACK; clear the 16-bit timer.
REQ-021 WAIT_ACK: act_s=1 goes to WAIT_REL with the timer cleared; timer==ack_timeout-1 with act_s=0 goes to FAIL.
REQ-022 WAIT_REL: act_s=0 goes to SETTLE with the timer cleared; timeout goes to FAIL.
REQ-023 SETTLE: when the timer reaches settle_cycles-1, set reset_done=1 and go to IDLE.
REQ-024 Latency: sw_reset_req in IDLE at cycle n SHALL give reset_start at cycle n+1.
REQ-025 sw_reset_req outside IDLE SHALL be ignored and never queued.
REQ-026 If act_s and the timeout coincide in a wait state, the act_s transition SHALL win.
REQ-027 The timer SHALL saturate and never wrap.

Reset
REQ-028 system_reset SHALL force POWERUP, clear all counters, and drive reset_start=0, reset_done=0, reset_error=0, retry_count=0, with reset_busy=1 and the synchronizer cleared.
REQ-029 system_reset mid-sequence SHALL abort the sequence and restart the power-up delay.

Configuration
REQ-030 With ADC_RESET_RETRY_EN defined, FAIL SHALL check retry_count: if retry_count<max_retries, increment it and go to ASSERT; otherwise set reset_error=1 and go to IDLE.
REQ-031 Without ADC_RESET_RETRY_EN, FAIL SHALL set reset_error=1 and go to IDLE, and retry_count SHALL stay 0.

Structure
REQ-032 Package adc_reset_pkg SHALL hold the state encoding, TIMER_W=16 and RETRY_W=4.
REQ-033 The synchronizer SHALL be sub-module adc_reset_sync, a 2-flop, 1-bit synchronizer.

Verification
REQ-034 Reset released with reset_time_delay=3 -> reset_start pulses once, 4 cycles after release; a model raising act 5 cycles and dropping it 20 cycles later -> reset_done=1 after settle.
REQ-035 In IDLE, sw_reset_req at cycle 100 -> reset_start at cycle 101; a second sw_reset_req at cycle 105 -> no extra pulse.
REQ-036 act never asserted, ack_timeout=8, retry disabled -> reset_error=1, back in IDLE, exactly one reset_start.
REQ-037 Same stimulus with ADC_RESET_RETRY_EN and max_retries=3 -> 4 reset_start pulses, retry_count=3, reset_error=1.
REQ-038 system_reset asserted during WAIT_REL -> next cycle state=POWERUP with all outputs at their reset values; the sequence then reruns and completes.

Source files
------------

// File: rtl/adc_reset_pkg.sv
// Shared constants for the ADC reset sequencer: FSM encoding and counter widths.
package adc_reset_pkg;

    localparam int TIMER_W = 16;
    localparam int RETRY_W = 4;
    localparam int STATE_W = 3;

    localparam logic [2:0] ST_POWERUP  = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_ASSERT   = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_WAIT_REL = 3'd4;
    localparam logic [2:0] ST_SETTLE   = 3'd5;
    localparam logic [2:0] ST_FAIL     = 3'd6;

endpackage

// File: rtl/adc_reset_sync.sv
// Two-flop single-bit synchronizer with synchronous active-high clear.
module adc_reset_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adc_reset_sequencer.sv
// ADC reset sequencer: power-up delay, start pulse, ack/release handshake, settle.
// Optional macro ADC_RESET_RETRY_EN enables bounded retries out of FAIL.
module adc_reset_sequencer
    import adc_reset_pkg::*;
#(
    parameter logic [31:0] reset_time_delay = 32'h3,
    parameter logic [15:0] ack_timeout      = 16'd1024,
    parameter logic [15:0] settle_cycles    = 16'd16,
    parameter logic [3:0]  max_retries      = 4'd3
) (
    input  logic       base_clk,
    input  logic       system_reset,
    input  logic       sw_reset_req,
    input  logic       adc_reset_active,
    output logic       reset_start,
    output logic       reset_busy,
    output logic       reset_done,
    output logic       reset_error,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    localparam logic [TIMER_W-1:0] ACK_LAST    = ack_timeout - 16'd1;
    localparam logic [TIMER_W-1:0] SETTLE_LAST = settle_cycles - 16'd1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] timer_inc;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               act_s;

    adc_reset_sync u_sync (
        .clk_i (base_clk),
        .rst_i (system_reset),
        .d_i   (adc_reset_active),
        .q_o   (act_s)
    );

    // Saturating increment keeps a stuck wait state from wrapping.
    assign timer_inc = (timer_q == {TIMER_W{1'b1}}) ? timer_q
                                                     : timer_q + TIMER_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        retry_d = retry_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            ST_POWERUP: begin
                if (cnt_q == reset_time_delay) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_IDLE: begin
                if (sw_reset_req) begin
                    state_d = ST_ASSERT;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    retry_d = '0;
                end
            end
            ST_ASSERT: begin
                state_d = ST_WAIT_ACK;
                timer_d = '0;
            end
            ST_WAIT_ACK: begin
                if (act_s) begin
                    state_d = ST_WAIT_REL;
                    timer_d = '0;
                end else if (timer_q == ACK_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_WAIT_REL: begin
                if (!act_s) begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                end else if (timer_q == ACK_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_FAIL: begin
`ifdef ADC_RESET_RETRY_EN
                if (retry_q < max_retries) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = ST_ASSERT;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
`else
                err_d   = 1'b1;
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_POWERUP;
                cnt_d   = '0;
            end
        endcase
    end

`ifndef ADC_RESET_RETRY_EN
    logic unused_cfg;
    assign unused_cfg = ^max_retries;
`endif

    always_ff @(posedge base_clk) begin
        if (system_reset) begin
            state_q <= ST_POWERUP;
            cnt_q   <= '0;
            timer_q <= '0;
            retry_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign reset_start = (state_q == ST_ASSERT);
    assign reset_busy  = (state_q != ST_IDLE);
    assign reset_done  = done_q;
    assign reset_error = err_q;
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_adc_reset_sequencer.sv
// Directed bench for adc_reset_sequencer: a default instance and a short-timeout one.
module tb_adc_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       m_rst, m_sw, m_act;
    logic       m_start, m_busy, m_done, m_err;
    logic [3:0] m_retry;
    logic [2:0] m_state;

    logic       t_rst, t_sw, t_act;
    logic       t_start, t_busy, t_done, t_err;
    logic [3:0] t_retry;
    logic [2:0] t_state;

    int errs = 0;
    int checks = 0;
    int m_pulses = 0;
    int t_pulses = 0;

    adc_reset_sequencer dut (
        .base_clk         (clk),
        .system_reset     (m_rst),
        .sw_reset_req     (m_sw),
        .adc_reset_active (m_act),
        .reset_start      (m_start),
        .reset_busy       (m_busy),
        .reset_done       (m_done),
        .reset_error      (m_err),
        .retry_count      (m_retry),
        .state            (m_state)
    );

    adc_reset_sequencer #(
        .ack_timeout (16'd8),
        .max_retries (4'd3)
    ) dut_t (
        .base_clk         (clk),
        .system_reset     (t_rst),
        .sw_reset_req     (t_sw),
        .adc_reset_active (t_act),
        .reset_start      (t_start),
        .reset_busy       (t_busy),
        .reset_done       (t_done),
        .reset_error      (t_err),
        .retry_count      (t_retry),
        .state            (t_state)
    );

    always @(posedge clk) begin
        if (m_start) m_pulses <= m_pulses + 1;
        if (t_start) t_pulses <= t_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0: return m_start;
            1: return m_done;
            2: return !m_busy;
            3: return m_state == 3'd4;
            4: return t_start;
            5: return t_done;
            6: return !t_busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int lim, input string tag,
                            output int n);
        n = 0;
        while (!cond(sel) && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(cond(sel)), 32'd1);
    endtask

    int n;
    int base;
    int exp_tries;
    int exp_idle;
    int exp_retry;

    initial begin
        m_rst = 1'b1; m_sw = 1'b0; m_act = 1'b0;
        t_rst = 1'b1; t_sw = 1'b0; t_act = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(m_state), 32'd0);
        check("rst_start", 32'(m_start), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd1);
        check("rst_done", 32'(m_done), 32'd0);
        check("rst_err", 32'(m_err), 32'd0);
        check("rst_retry", 32'(m_retry), 32'd0);

        // power-up sequence with a well-behaved ADC
        base = m_pulses;
        m_rst = 1'b0;
        wait_for(0, 20, "pwr_start_seen", n);
        check("pwr_latency", n, 32'd4);
        repeat (5) @(posedge clk);
        #1;
        check("pwr_wait_ack", 32'(m_state), 32'd3);
        m_act = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("pwr_wait_rel", 32'(m_state), 32'd4);
        m_act = 1'b0;
        wait_for(1, 40, "pwr_done_seen", n);
        check("pwr_settle_lat", n, 32'd19);
        check("pwr_idle", 32'(m_state), 32'd1);
        check("pwr_busy", 32'(m_busy), 32'd0);
        check("pwr_err", 32'(m_err), 32'd0);
        check("pwr_pulses", m_pulses - base, 32'd1);

        // software request latency and a second request that must be dropped
        repeat (3) @(posedge clk);
        #1;
        base = m_pulses;
        m_sw = 1'b1;
        @(posedge clk);
        #1;
        m_sw = 1'b0;
        check("sw_latency", 32'(m_start), 32'd1);
        check("sw_done_clr", 32'(m_done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        m_sw = 1'b1;
        @(posedge clk);
        #1;
        m_sw = 1'b0;
        check("sw_ignored_state", 32'(m_state), 32'd3);
        check("sw_ignored_start", 32'(m_start), 32'd0);
        m_act = 1'b1;
        wait_for(3, 10, "sw_rel_seen", n);
        m_act = 1'b0;
        wait_for(1, 40, "sw_done_seen", n);
        check("sw_pulses", m_pulses - base, 32'd1);

        // system reset in the middle of WAIT_REL
        m_sw = 1'b1;
        @(posedge clk);
        #1;
        m_sw = 1'b0;
        m_act = 1'b1;
        wait_for(3, 10, "abort_rel_seen", n);
        m_rst = 1'b1;
        m_act = 1'b0;
        @(posedge clk);
        #1;
        check("abort_state", 32'(m_state), 32'd0);
        check("abort_start", 32'(m_start), 32'd0);
        check("abort_busy", 32'(m_busy), 32'd1);
        check("abort_done", 32'(m_done), 32'd0);
        check("abort_err", 32'(m_err), 32'd0);
        check("abort_retry", 32'(m_retry), 32'd0);
        m_rst = 1'b0;
        wait_for(0, 20, "rerun_start_seen", n);
        check("rerun_latency", n, 32'd4);
        m_act = 1'b1;
        wait_for(3, 10, "rerun_rel_seen", n);
        m_act = 1'b0;
        wait_for(1, 40, "rerun_done_seen", n);
        check("rerun_err", 32'(m_err), 32'd0);

        // ack arriving on the very last timeout cycle must win
        t_rst = 1'b0;
        wait_for(4, 20, "t_start_seen", n);
        repeat (6) @(posedge clk);
        #1;
        t_act = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("edge_still_ack", 32'(t_state), 32'd3);
        @(posedge clk);
        #1;
        check("edge_act_wins", 32'(t_state), 32'd4);
        t_act = 1'b0;
        wait_for(5, 40, "edge_done_seen", n);
        check("edge_err", 32'(t_err), 32'd0);

        // ADC never acknowledges
`ifdef ADC_RESET_RETRY_EN
        exp_tries = 4; exp_idle = 40; exp_retry = 3;
`else
        exp_tries = 1; exp_idle = 10; exp_retry = 0;
`endif
        base = t_pulses;
        t_sw = 1'b1;
        @(posedge clk);
        #1;
        t_sw = 1'b0;
        check("to_start", 32'(t_start), 32'd1);
        wait_for(6, 100, "to_idle_seen", n);
        check("to_idle_lat", n, exp_idle);
        check("to_err", 32'(t_err), 32'd1);
        check("to_done", 32'(t_done), 32'd0);
        check("to_state", 32'(t_state), 32'd1);
        check("to_retry", 32'(t_retry), exp_retry);
        check("to_pulses", t_pulses - base, exp_tries);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
